washer_motor_drive: RTL and testbench

//  Downstream of the washing-machine control FSM. Consumes its one-hot phase enables (soak/wash/rinse/spin)
//  and the lid input, and drives the drum motor: PWM duty with soft ramps, agitation direction reversal with

---
 rtl/washer_motor_drive.sv | 178 +++++++++++++++++
 tb/tb_washer_motor_drive.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/washer_motor_drive.sv
// rtl/washer_motor_drive.sv - drum motor drive: PWM soft ramps, agitation reversal, spin, lid interlock, fault latch
// Optional active braking and faster coast-down selected by MOTOR_BRAKE_EN.
module washer_motor_drive #(
    parameter int PWM_BITS       = 8,
    parameter int RAMP_DIV       = 16,
    parameter int RAMP_STEP      = 4,
    parameter int WASH_DUTY      = 128,
    parameter int RINSE_DUTY     = 96,
    parameter int SPIN_DUTY      = 255,
    parameter int AGITATE_CYCLES = 64,
    parameter int DEAD_CYCLES    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                soak_en,
    input  logic                wash_en,
    input  logic                rinse_en,
    input  logic                spin_en,
    input  logic                lid,
    output logic                motor_pwm,
    output logic                motor_dir,
    output logic                motor_brake,
    output logic                lid_lock,
    output logic                motor_busy,
    output logic                fault,
    output logic [PWM_BITS-1:0] duty
);

    typedef enum logic [2:0] {S_IDLE, S_RAMP, S_RUN, S_COAST, S_DEAD, S_FAULT} state_t;

`ifdef MOTOR_BRAKE_EN
    localparam int COAST_STEP = 2 * RAMP_STEP;
`else
    localparam int COAST_STEP = RAMP_STEP;
`endif

    localparam int HOLD_MAX = (AGITATE_CYCLES > DEAD_CYCLES) ? AGITATE_CYCLES : DEAD_CYCLES;
    localparam int RCW      = $clog2(RAMP_DIV + 1);
    localparam int HCW      = $clog2(HOLD_MAX + 1);

    localparam logic [PWM_BITS:0]   STEP_UP    = RAMP_STEP[PWM_BITS:0];
    localparam logic [PWM_BITS:0]   STEP_DN    = COAST_STEP[PWM_BITS:0];
    localparam logic [PWM_BITS-1:0] WASH_T     = WASH_DUTY[PWM_BITS-1:0];
    localparam logic [PWM_BITS-1:0] RINSE_T    = RINSE_DUTY[PWM_BITS-1:0];
    localparam logic [PWM_BITS-1:0] SPIN_T     = SPIN_DUTY[PWM_BITS-1:0];
    localparam logic [RCW-1:0]      RAMP_LAST  = RCW'(RAMP_DIV - 1);
    localparam logic [HCW-1:0]      AGIT_LAST  = HCW'(AGITATE_CYCLES - 1);
    localparam logic [HCW-1:0]      DEAD_LAST  = HCW'(DEAD_CYCLES - 1);
    localparam logic [HCW-1:0]      HOLD_SAT   = '1;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] tgt_q, tgt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [RCW-1:0]      ramp_cnt_q, ramp_cnt_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
    logic                dir_q, dir_d;
    logic                pwm_q, pwm_d;
    logic                lock_q, lock_d;

    logic [2:0]          n_en;
    logic                any_en, agit_now, fault_req, tick;
    logic [PWM_BITS-1:0] target, up_sat, dn_sat;
    logic [PWM_BITS:0]   up_sum, dn_diff;

    always_comb begin
        n_en      = {2'b0, soak_en} + {2'b0, wash_en} + {2'b0, rinse_en} + {2'b0, spin_en};
        any_en    = soak_en | wash_en | rinse_en | spin_en;
        agit_now  = wash_en | rinse_en;
        fault_req = (n_en > 3'd1) | (lid & lock_q);
        tick      = (ramp_cnt_q == RAMP_LAST);
        if (wash_en)       target = WASH_T;
        else if (rinse_en) target = RINSE_T;
        else if (spin_en)  target = SPIN_T;
        else               target = '0;
        // One extra bit catches the carry out of the add and the borrow of the subtract.
        up_sum  = {1'b0, duty_q} + STEP_UP;
        dn_diff = {1'b0, duty_q} - STEP_DN;
        up_sat  = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[PWM_BITS-1:0];
        dn_sat  = dn_diff[PWM_BITS] ? '0 : dn_diff[PWM_BITS-1:0];
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        dir_d   = dir_q;
        if (fault_req) begin
            state_d = S_FAULT;
            duty_d  = '0;
            dir_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (target != '0) begin
                    state_d = S_RAMP;
                    tgt_d   = target;
                    dir_d   = 1'b0;
                end
                S_RAMP: if (target != tgt_q) begin
                    state_d = S_COAST;
                end else if (tick) begin
                    duty_d = up_sat;
                    if (up_sat == tgt_q) state_d = S_RUN;
                end
                S_RUN: if (target != tgt_q || (agit_now && hold_cnt_q == AGIT_LAST)) begin
                    state_d = S_COAST;
                end
                S_COAST: if (duty_q == '0) begin
                    state_d = S_DEAD;
                end else if (tick) begin
                    duty_d = dn_sat;
                    if (dn_sat == '0) state_d = S_DEAD;
                end
                S_DEAD: if (hold_cnt_q == DEAD_LAST) begin
                    if (target == tgt_q && agit_now) begin
                        dir_d   = ~dir_q;
                        state_d = S_RAMP;
                    end else if (target != '0) begin
                        dir_d   = 1'b0;
                        tgt_d   = target;
                        state_d = S_RAMP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FAULT: if (!any_en && !lid) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        pwm_d      = (pwm_cnt_d < duty_d);
        lock_d     = spin_en | (duty_d != '0) | (state_d == S_RAMP) | (state_d == S_RUN);
        ramp_cnt_d = (state_d != state_q || tick) ? '0 : ramp_cnt_q + 1'b1;
        if (state_d != state_q)       hold_cnt_d = '0;
        else if (hold_cnt_q == HOLD_SAT) hold_cnt_d = hold_cnt_q;
        else                          hold_cnt_d = hold_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            duty_q     <= '0;
            tgt_q      <= '0;
            pwm_cnt_q  <= '0;
            ramp_cnt_q <= '0;
            hold_cnt_q <= '0;
            dir_q      <= 1'b0;
            pwm_q      <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            tgt_q      <= tgt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            dir_q      <= dir_d;
            pwm_q      <= pwm_d;
            lock_q     <= lock_d;
        end
    end

    assign motor_pwm  = pwm_q;
    assign motor_dir  = dir_q;
    assign lid_lock   = lock_q;
    assign motor_busy = (state_q != S_IDLE);
    assign fault      = (state_q == S_FAULT);
    assign duty       = duty_q;
`ifdef MOTOR_BRAKE_EN
    assign motor_brake = (state_q == S_COAST) | (state_q == S_DEAD) | (state_q == S_FAULT);
`else
    assign motor_brake = 1'b0;
`endif

endmodule

// File: tb/tb_washer_motor_drive.sv
// tb/tb_washer_motor_drive.sv - directed and randomized checks of washer_motor_drive against a phase-level model
module tb_washer_motor_drive;

    localparam int P_DIV   = 4;
    localparam int P_STEP  = 32;
    localparam int P_WASH  = 128;
    localparam int P_RINSE = 96;
    localparam int P_SPIN  = 255;
    localparam int P_AGIT  = 16;
    localparam int P_DEAD  = 4;
`ifdef MOTOR_BRAKE_EN
    localparam int P_CSTEP = 2 * P_STEP;
    localparam bit P_BRAKE = 1'b1;
`else
    localparam int P_CSTEP = P_STEP;
    localparam bit P_BRAKE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soak_en = 1'b0, wash_en = 1'b0, rinse_en = 1'b0, spin_en = 1'b0, lid = 1'b0;
    logic       motor_pwm, motor_dir, motor_brake, lid_lock, motor_busy, fault;
    logic [7:0] duty;

    int n_checks = 0;
    int n_errors = 0;

    washer_motor_drive #(
        .PWM_BITS(8), .RAMP_DIV(P_DIV), .RAMP_STEP(P_STEP), .WASH_DUTY(P_WASH),
        .RINSE_DUTY(P_RINSE), .SPIN_DUTY(P_SPIN), .AGITATE_CYCLES(P_AGIT), .DEAD_CYCLES(P_DEAD)
    ) dut (
        .clk(clk), .rst(rst), .soak_en(soak_en), .wash_en(wash_en), .rinse_en(rinse_en),
        .spin_en(spin_en), .lid(lid), .motor_pwm(motor_pwm), .motor_dir(motor_dir),
        .motor_brake(motor_brake), .lid_lock(lid_lock), .motor_busy(motor_busy),
        .fault(fault), .duty(duty)
    );

    always #5 clk = ~clk;

    // Model phases: what the motor is doing, and how long it has been doing it.
    localparam int PH_OFF = 0, PH_UP = 1, PH_HOLD = 2, PH_DOWN = 3, PH_REST = 4, PH_TRIP = 5;
    int m_ph, m_age, m_duty, m_goal, m_dir, m_lock, m_slot, m_pwm;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_OFF; m_age = 0; m_duty = 0; m_goal = 0;
        m_dir = 0; m_lock = 0; m_slot = 0; m_pwm = 0;
    endtask

    task automatic model_step();
        int wanted, nen, nph, ag;
        bit ramp_edge;
        nen    = int'(soak_en) + int'(wash_en) + int'(rinse_en) + int'(spin_en);
        wanted = wash_en ? P_WASH : rinse_en ? P_RINSE : spin_en ? P_SPIN : 0;
        ag     = int'(wash_en | rinse_en);
        ramp_edge = ((m_age + 1) % P_DIV) == 0;
        nph = m_ph;
        if (nen > 1 || (lid && m_lock == 1)) begin
            nph = PH_TRIP; m_duty = 0; m_dir = 0;
        end else if (m_ph == PH_OFF) begin
            if (wanted > 0) begin nph = PH_UP; m_goal = wanted; m_dir = 0; end
        end else if (m_ph == PH_UP) begin
            if (wanted != m_goal) nph = PH_DOWN;
            else if (ramp_edge) begin
                m_duty = (m_duty + P_STEP > m_goal) ? m_goal : m_duty + P_STEP;
                if (m_duty == m_goal) nph = PH_HOLD;
            end
        end else if (m_ph == PH_HOLD) begin
            if (wanted != m_goal || (ag == 1 && m_age + 1 == P_AGIT)) nph = PH_DOWN;
        end else if (m_ph == PH_DOWN) begin
            if (m_duty == 0) nph = PH_REST;
            else if (ramp_edge) begin
                m_duty = (m_duty < P_CSTEP) ? 0 : m_duty - P_CSTEP;
                if (m_duty == 0) nph = PH_REST;
            end
        end else if (m_ph == PH_REST) begin
            if (m_age + 1 == P_DEAD) begin
                if (wanted == m_goal && ag == 1) begin m_dir = 1 - m_dir; nph = PH_UP; end
                else if (wanted > 0) begin m_dir = 0; m_goal = wanted; nph = PH_UP; end
                else nph = PH_OFF;
            end
        end else begin
            if (nen == 0 && !lid) nph = PH_OFF;
        end
        m_age  = (nph == m_ph) ? m_age + 1 : 0;
        m_ph   = nph;
        m_slot = (m_slot + 1) % 256;
        m_pwm  = int'(m_slot < m_duty);
        m_lock = int'(spin_en || m_duty != 0 || m_ph == PH_UP || m_ph == PH_HOLD);
    endtask

    task automatic compare_all();
        check("duty", int'(duty), m_duty);
        check("motor_dir", int'(motor_dir), m_dir);
        check("motor_pwm", int'(motor_pwm), m_pwm);
        check("lid_lock", int'(lid_lock), m_lock);
        check("motor_busy", int'(motor_busy), int'(m_ph != PH_OFF));
        check("fault", int'(fault), int'(m_ph == PH_TRIP));
        check("motor_brake", int'(motor_brake),
              int'(P_BRAKE && (m_ph == PH_DOWN || m_ph == PH_REST || m_ph == PH_TRIP)));
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic set_in(input bit s, input bit w, input bit r, input bit p, input bit l);
        soak_en = s; wash_en = w; rinse_en = r; spin_en = p; lid = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int highs, saw_rev, pick, len;
        model_reset();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Wash from idle: ramp, hold, coast, dead time, reversed re-ramp.
        set_in(0, 1, 0, 0, 0);
        saw_rev = 0;
        for (int i = 1; i <= 200; i++) begin
            run_cycle();
            if (i == 5)  check("t1_first_step", int'(duty), 32);
            if (i == 17) check("t1_at_target", int'(duty), 128);
            if (i == 17) check("t1_lid_lock", int'(lid_lock), 1);
            if (motor_dir) saw_rev = 1;
        end
        check("t2_reversed", saw_rev, 1);
        set_in(0, 0, 0, 0, 0);
        repeat (60) run_cycle();
        check("t2_idle", int'(motor_busy), 0);

        // Spin saturates at full duty and never reverses.
        set_in(0, 0, 0, 1, 0);
        highs = 0;
        for (int i = 1; i <= 300; i++) begin
            run_cycle();
            if (i > 44) highs += int'(motor_pwm);
        end
        check("t3_spin_duty", int'(duty), 255);
        check("t3_pwm_highs", highs, 255);

        // Lid opened mid-spin trips immediately and stays tripped until spin and lid drop.
        set_in(0, 0, 0, 1, 1);
        run_cycle();
        check("t4_fault", int'(fault), 1);
        check("t4_duty", int'(duty), 0);
        check("t4_pwm", int'(motor_pwm), 0);
        set_in(0, 0, 0, 1, 0);
        repeat (10) run_cycle();
        check("t4_fault_held", int'(fault), 1);
        set_in(0, 0, 0, 0, 0);
        run_cycle();
        check("t4_fault_clear", int'(fault), 0);

        // Two phases at once.
        set_in(0, 1, 0, 1, 0);
        run_cycle();
        check("t5_fault", int'(fault), 1);
        check("t5_duty", int'(duty), 0);
        set_in(0, 0, 0, 0, 0);
        repeat (3) run_cycle();

        // Asynchronous reset mid-ramp.
        do_reset();
        set_in(0, 1, 0, 0, 0);
        repeat (13) run_cycle();
        check("t6_pre_duty", int'(duty), 96);
        #2 rst = 1'b1;
        #1;
        check("t6_duty", int'(duty), 0);
        check("t6_lock", int'(lid_lock), 0);
        check("t6_busy", int'(motor_busy), 0);
        check("t6_pwm", int'(motor_pwm), 0);
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();
        run_cycle();
        check("t6_idle", int'(motor_busy), 0);

        // Randomized phase sequences with occasional lid openings, overlaps and resets.
        for (int seg = 0; seg < 60; seg++) begin
            pick = $urandom_range(0, 19);
            len  = $urandom_range(4, 150);
            if (pick == 0) begin
                set_in(0, 0, 0, 0, 0);
                do_reset();
            end else if (pick <= 2) begin
                set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
                len = 2;
            end
            for (int c = 0; c < len; c++) begin
                if (pick > 2) begin
                    set_in(pick % 6 == 3, pick % 6 == 4 || pick % 6 == 0, pick % 6 == 5,
                           pick % 6 == 1, 0);
                    if (pick % 6 == 2) set_in(0, 0, 0, 0, 0);
                end
                lid = ($urandom_range(0, 39) == 0);
                run_cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
